spi_master_b2b: RTL and testbench



---
 rtl/spi_master_b2b_if.sv | 23 ++
 rtl/spi_master_b2b.sv | 197 +++++++++++++++++++
 tb/tb_spi_master_b2b.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_b2b_if.sv
// Board-to-board SPI master bundle: controller handshake (start/busy/rx/done) plus the SPI pins.
interface spi_master_b2b_if;
  logic       start;
  logic       busy;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] byte_cnt;
  logic       done;
  logic       sck;
  logic       mosi;
  logic       ssel;
  logic       miso;

  modport master (
    input  start, miso,
    output busy, rx_byte, rx_valid, byte_cnt, done, sck, mosi, ssel
  );

  modport slave (
    output start, miso,
    input  busy, rx_byte, rx_valid, byte_cnt, done, sck, mosi, ssel
  );
endinterface

// File: rtl/spi_master_b2b.sv
// SPI mode-0 frame master: on start, sends NUM_BYTES incrementing bytes MSB first and returns each miso byte.
// All outputs registered; start is only accepted in IDLE, and there is no backpressure on rx_valid/done.
module spi_master_b2b #(
  parameter int         CLK_DIV     = 4,
  parameter int         NUM_BYTES   = 64,
  parameter logic [7:0] FIRST_VALUE = 8'h01,
  parameter int         SSEL_GUARD  = 8,
  parameter int         BYTE_GAP    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_b2b_if.master bus
);

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GUARD_M1 = 8'(SSEL_GUARD - 1);
  localparam logic [7:0] GAP_M1   = (BYTE_GAP > 0) ? 8'(BYTE_GAP - 1) : 8'd0;
  localparam logic [7:0] NB       = 8'(NUM_BYTES);

  typedef enum logic [2:0] {
    IDLE, LEAD, BIT_LO, BIT_HI, GAP, TRAIL, FINISH
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_val_q, tx_val_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       sck_q, sck_d;
  logic       ssel_q, ssel_d;
  logic       busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d;
  logic       done_q, done_d;
  logic       miso_s1, miso_s2;

  logic [7:0] rx_shifted;
  logic [7:0] byte_inc;
  logic [7:0] tx_next;

  assign rx_shifted = {rx_sh_q[6:0], miso_s2};
  assign byte_inc   = byte_cnt_q + 8'd1;
  assign tx_next    = tx_val_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_val_d   = tx_val_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    byte_cnt_d = byte_cnt_q;
    sck_d      = sck_q;
    ssel_d     = ssel_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = LEAD;
          cnt_d      = GUARD_M1;
          bit_d      = 3'd0;
          tx_val_d   = FIRST_VALUE;
          tx_sh_d    = FIRST_VALUE;
          byte_cnt_d = 8'd0;
          ssel_d     = 1'b0;
          busy_d     = 1'b1;
          sck_d      = 1'b0;
        end
      end
      LEAD: begin
        if (cnt_q == 8'd0) begin
          state_d = BIT_LO;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BIT_LO: begin
        if (cnt_q == 8'd0) begin
          state_d = BIT_HI;
          cnt_d   = DIV_M1;
          sck_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BIT_HI: begin
        if (cnt_q == 8'd0) begin
          // sck falls and mosi advances on the same edge
          sck_d   = 1'b0;
          rx_sh_d = rx_shifted;
          bit_d   = bit_q + 3'd1;
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
          state_d = BIT_LO;
          cnt_d   = DIV_M1;
          if (bit_q == 3'd7) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shifted;
            byte_cnt_d = byte_inc;
            if (byte_inc == NB) begin
              state_d = TRAIL;
              cnt_d   = GUARD_M1;
              tx_sh_d = 8'd0;
            end else begin
              tx_val_d = tx_next;
              tx_sh_d  = tx_next;
              if (BYTE_GAP > 0) begin
                state_d = GAP;
                cnt_d   = GAP_M1;
              end
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = BIT_LO;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      TRAIL: begin
        if (cnt_q == 8'd0) begin
          state_d = FINISH;
          ssel_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_sh_d = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 3'd0;
      tx_val_q   <= 8'd0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      rx_byte_q  <= 8'd0;
      byte_cnt_q <= 8'd0;
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      miso_s1    <= 1'b0;
      miso_s2    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_val_q   <= tx_val_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      byte_cnt_q <= byte_cnt_d;
      sck_q      <= sck_d;
      ssel_q     <= ssel_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      miso_s1    <= bus.miso;
      miso_s2    <= miso_s1;
    end
  end

  // mosi is the MSB of the shift register, so it stays a plain flop output
  assign bus.mosi     = tx_sh_q[7];
  assign bus.sck      = sck_q;
  assign bus.ssel     = ssel_q;
  assign bus.busy     = busy_q;
  assign bus.rx_byte  = rx_byte_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.byte_cnt = byte_cnt_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_master_b2b.sv
// Bench for spi_master_b2b: four configurations (loopback, wrap, miso high with gaps, slave model) on one clock.
module tb_spi_master_b2b;

  localparam int CD = 4;
  localparam int SG = 8;

  logic clk;
  logic rst_n;
  logic rst_d_n;

  spi_master_b2b_if bus_a ();
  spi_master_b2b_if bus_b ();
  spi_master_b2b_if bus_c ();
  spi_master_b2b_if bus_d ();

  spi_master_b2b #(.CLK_DIV(CD), .NUM_BYTES(3), .FIRST_VALUE(8'h01), .SSEL_GUARD(SG), .BYTE_GAP(0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  spi_master_b2b #(.CLK_DIV(CD), .NUM_BYTES(4), .FIRST_VALUE(8'hFE), .SSEL_GUARD(SG), .BYTE_GAP(0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  spi_master_b2b #(.CLK_DIV(CD), .NUM_BYTES(3), .FIRST_VALUE(8'h01), .SSEL_GUARD(SG), .BYTE_GAP(5))
    u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
  spi_master_b2b #(.CLK_DIV(CD), .NUM_BYTES(64), .FIRST_VALUE(8'h01), .SSEL_GUARD(SG), .BYTE_GAP(0))
    u_d (.clk(clk), .rst_n(rst_d_n), .bus(bus_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // far-board slave model: returns a preloaded A5 first, then echoes each received byte
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic [7:0] sl_next = 8'h00;
  int         sl_bits = 0;
  bit         sl_load = 1'b0;
  int         sl_k = 0;

  assign bus_a.miso = bus_a.mosi;
  assign bus_b.miso = bus_b.mosi;
  assign bus_c.miso = 1'b1;
  assign bus_d.miso = sl_tx[7];

  logic [3:0] ssel_v, sck_v, mosi_v, busy_v, rxv_v, done_v, rst_v;
  logic [7:0] rxb_v [4];
  logic [7:0] bc_v  [4];
  assign ssel_v = {bus_d.ssel, bus_c.ssel, bus_b.ssel, bus_a.ssel};
  assign sck_v  = {bus_d.sck, bus_c.sck, bus_b.sck, bus_a.sck};
  assign mosi_v = {bus_d.mosi, bus_c.mosi, bus_b.mosi, bus_a.mosi};
  assign busy_v = {bus_d.busy, bus_c.busy, bus_b.busy, bus_a.busy};
  assign rxv_v  = {bus_d.rx_valid, bus_c.rx_valid, bus_b.rx_valid, bus_a.rx_valid};
  assign done_v = {bus_d.done, bus_c.done, bus_b.done, bus_a.done};
  assign rst_v  = {rst_d_n, rst_n, rst_n, rst_n};
  assign rxb_v[0] = bus_a.rx_byte;
  assign rxb_v[1] = bus_b.rx_byte;
  assign rxb_v[2] = bus_c.rx_byte;
  assign rxb_v[3] = bus_d.rx_byte;
  assign bc_v[0]  = bus_a.byte_cnt;
  assign bc_v[1]  = bus_b.byte_cnt;
  assign bc_v[2]  = bus_c.byte_cnt;
  assign bc_v[3]  = bus_d.byte_cnt;

  logic [7:0] fv [4] = '{8'h01, 8'hFE, 8'h01, 8'h01};
  int         gap_v [4] = '{0, 0, 5, 0};

  int n_cmp = 0;
  int n_bad = 0;

  int rxc [4] = '{0, 0, 0, 0};
  int donec [4] = '{0, 0, 0, 0};
  int last_len [4] = '{0, 0, 0, 0};
  string rx_log = "";

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic q_push(input int i, input logic [7:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int i, output logic [7:0] v, output bit ok);
    ok = 1'b0;
    v  = 8'h00;
    case (i)
      0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin v = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic set_start(input int i, input logic v);
    case (i)
      0: bus_a.start = v;
      1: bus_b.start = v;
      2: bus_c.start = v;
      default: bus_d.start = v;
    endcase
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    set_start(i, 1'b1);
    @(negedge clk);
    set_start(i, 1'b0);
  endtask

  task automatic push_frame(input int i, input int nb);
    for (int k = 0; k < nb; k++) begin
      logic [7:0] e;
      case (i)
        2:       e = 8'hFF;
        3:       e = (k == 0) ? 8'hA5 : fv[i] + 8'(k - 1);
        default: e = fv[i] + 8'(k);
      endcase
      q_push(i, e);
    end
  endtask

  task automatic wait_rx(input int i, input int target, input int budget);
    int n = 0;
    while (rxc[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("rx_wait_%0d", i), 32'(rxc[i] >= target), 1);
  endtask

  task automatic wait_done(input int i, input int base, input int budget);
    int n = 0;
    while (donec[i] == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_wait_%0d", i), 32'(donec[i] != base), 1);
  endtask

  // link monitor: phase lengths, mosi edges, frame length, scoreboard pops
  initial begin
    bit   p_ssel [4] = '{1, 1, 1, 1};
    bit   p_sck  [4] = '{0, 0, 0, 0};
    bit   p_mosi [4] = '{0, 0, 0, 0};
    int   lo_run [4] = '{0, 0, 0, 0};
    int   hi_run [4] = '{0, 0, 0, 0};
    int   rise_idx [4] = '{0, 0, 0, 0};
    int   ssel_run [4] = '{0, 0, 0, 0};
    int   e;
    logic [7:0] ev;
    bit   ok;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rst_v[i] !== 1'b1) begin
          p_ssel[i] = 1'b1; p_sck[i] = 1'b0; p_mosi[i] = 1'b0;
          lo_run[i] = 0; hi_run[i] = 0; rise_idx[i] = 0; ssel_run[i] = 0;
        end else begin
          if (ssel_v[i] == 1'b0) begin
            if (p_ssel[i]) begin
              ssel_run[i] = 0; lo_run[i] = 0; rise_idx[i] = 0;
            end
            ssel_run[i]++;
            if (sck_v[i]) begin
              if (!p_sck[i]) begin
                if (rise_idx[i] == 0)          e = SG + CD;
                else if (rise_idx[i] % 8 == 0) e = CD + gap_v[i];
                else                           e = CD;
                check($sformatf("sck_low_%0d_%0d", i, rise_idx[i]), lo_run[i], e);
                rise_idx[i]++;
                hi_run[i] = 0;
              end
              hi_run[i]++;
            end else begin
              if (p_sck[i]) begin
                check($sformatf("sck_high_%0d_%0d", i, rise_idx[i]), hi_run[i], CD);
                lo_run[i] = 0;
              end
              lo_run[i]++;
            end
            if (!p_ssel[i] && mosi_v[i] !== p_mosi[i])
              check($sformatf("mosi_edge_%0d", i), 32'(p_sck[i] && !sck_v[i]), 1);
          end else if (!p_ssel[i]) begin
            last_len[i] = ssel_run[i];
            check($sformatf("trail_%0d", i), lo_run[i], SG);
          end
          if (rxv_v[i]) begin
            rxc[i]++;
            q_pop(i, ev, ok);
            check($sformatf("rx_expected_%0d", i), 32'(ok), 1);
            if (ok) check($sformatf("rx_byte_%0d_%0d", i, rxc[i]), rxb_v[i], ev);
            if (i == 3) rx_log = {rx_log, $sformatf(" %02h", rxb_v[i])};
          end
          if (done_v[i]) donec[i]++;
          p_ssel[i] = ssel_v[i];
          p_sck[i]  = sck_v[i];
          p_mosi[i] = mosi_v[i];
        end
      end
    end
  end

  initial forever begin
    @(negedge bus_d.ssel);
    sl_tx = 8'hA5; sl_bits = 0; sl_load = 1'b0; sl_k = 0;
  end

  initial forever begin
    @(posedge bus_d.sck);
    if (rst_d_n && !bus_d.ssel) begin
      sl_rx = {sl_rx[6:0], bus_d.mosi};
      sl_bits++;
      if (sl_bits == 8) begin
        check($sformatf("slave_byte_%0d", sl_k), sl_rx, 8'h01 + 8'(sl_k));
        sl_next = sl_rx;
        sl_load = 1'b1;
        sl_bits = 0;
        sl_k++;
      end
    end
  end

  initial forever begin
    @(negedge bus_d.sck);
    if (sl_load) begin
      sl_tx = sl_next;
      sl_load = 1'b0;
    end else begin
      sl_tx = {sl_tx[6:0], 1'b0};
    end
  end

  typedef struct {
    int inst;
    int nbytes;
    int ssel_low;
    bit poke;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   base_done;
    int   base_rx;

    vecs[0] = '{0, 3, 2*SG + 3*16*CD, 1'b0};
    vecs[1] = '{1, 4, 2*SG + 4*16*CD, 1'b0};
    vecs[2] = '{2, 3, 2*SG + 3*16*CD + 2*5, 1'b1};
    vecs[3] = '{3, 64, 2*SG + 64*16*CD, 1'b0};

    rst_n = 1'b0;
    rst_d_n = 1'b0;
    bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0; bus_d.start = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ssel_%0d", i), ssel_v[i], 1);
      check($sformatf("rst_sck_%0d", i), sck_v[i], 0);
      check($sformatf("rst_mosi_%0d", i), mosi_v[i], 0);
      check($sformatf("rst_busy_%0d", i), busy_v[i], 0);
      check($sformatf("rst_rxv_%0d", i), rxv_v[i], 0);
      check($sformatf("rst_done_%0d", i), done_v[i], 0);
      check($sformatf("rst_rxb_%0d", i), rxb_v[i], 0);
      check($sformatf("rst_bc_%0d", i), bc_v[i], 0);
    end
    rst_n = 1'b1;
    rst_d_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ssel", bus_a.ssel, 1);
    check("idle_busy", bus_a.busy, 0);

    // abort a 64-byte frame during byte 2 with an asynchronous reset
    base_done = donec[3];
    push_frame(3, 64);
    pulse_start(3);
    wait_rx(3, 1, 2000);
    repeat (20) @(negedge clk);
    #2 rst_d_n = 1'b0;
    #1;
    check("abort_ssel", bus_d.ssel, 1);
    check("abort_sck", bus_d.sck, 0);
    check("abort_busy", bus_d.busy, 0);
    check("abort_done", bus_d.done, 0);
    check("abort_rxv", bus_d.rx_valid, 0);
    q3.delete();
    repeat (3) @(negedge clk);
    rst_d_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", donec[3], base_done);
    check("abort_ssel_idle", bus_d.ssel, 1);

    for (int v = 0; v < 4; v++) begin
      int i;
      i = vecs[v].inst;
      base_done = donec[i];
      base_rx = rxc[i];
      if (i == 3) rx_log = "";
      push_frame(i, vecs[v].nbytes);
      pulse_start(i);
      check($sformatf("start_busy_%0d", i), busy_v[i], 1);
      check($sformatf("start_ssel_%0d", i), ssel_v[i], 0);
      check($sformatf("start_bc_%0d", i), bc_v[i], 0);
      if (vecs[v].poke) begin
        wait_rx(i, base_rx + 1, 2000);
        pulse_start(i);
      end
      wait_done(i, base_done, 10000);
      repeat (3) @(negedge clk);
      check($sformatf("rx_count_%0d", i), rxc[i] - base_rx, vecs[v].nbytes);
      check($sformatf("done_count_%0d", i), donec[i] - base_done, 1);
      check($sformatf("byte_cnt_%0d", i), bc_v[i], vecs[v].nbytes);
      check($sformatf("ssel_low_%0d", i), last_len[i], vecs[v].ssel_low);
      check($sformatf("end_busy_%0d", i), busy_v[i], 0);
      check($sformatf("end_ssel_%0d", i), ssel_v[i], 1);
    end

    check("slave_bytes", sl_k, 64);
    check("queues_empty", q0.size() + q1.size() + q2.size() + q3.size(), 0);
    $display("inst3 rx_byte log:%s", rx_log);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

endmodule
